stopwatch_ctrl: RTL

//  Run/pause/lap/clear sequencer for the 00:00.00 stopwatch counter chain.

---
 rtl/stopwatch_pkg.sv | 17 +
 rtl/stopwatch_if.sv | 24 ++
 rtl/button_debounce.sv | 51 +++++
 rtl/stopwatch_ctrl.sv | 87 ++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and helpers for the stopwatch control slice.
// State encodings as seen on the state output, debounce length helper.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_LAP   = 2'b11
    } state_t;

    // Stable clock cycles needed before a button level is accepted
    function automatic int db_cnt(input int clk_hz, input int ms);
        return clk_hz / 1000 * ms;
    endfunction

endpackage

// File: rtl/stopwatch_if.sv
// Board-side bundle of the stopwatch controller: buttons and tick in,
// counter-chain and display controls out.
interface stopwatch_if;
    import stopwatch_pkg::*;

    logic   btn_ss;
    logic   btn_lc;
    logic   tick_in;
    logic   cnt_en;
    logic   cnt_clr;
    logic   disp_hold;
    state_t state;

    modport master (
        output btn_ss, btn_lc, tick_in,
        input  cnt_en, cnt_clr, disp_hold, state
    );

    modport slave (
        input  btn_ss, btn_lc, tick_in,
        output cnt_en, cnt_clr, disp_hold, state
    );

endinterface

// File: rtl/button_debounce.sv
// Raw push-button to single-cycle press pulse: 2-FF synchroniser,
// stable-time debounce, rising-edge pulse on the accepted level.
module button_debounce #(
    parameter int DB_CNT = 4,
    parameter int DB_W   = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic press
);

    localparam logic [DB_W-1:0] CNT_MAX = DB_W'(DB_CNT - 1);

    logic            sync1;
    logic            sync2;
    logic            level;
    logic [DB_W-1:0] cnt;

    // Bring the asynchronous button into the clk domain
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Accept a new level only after it has held for DB_CNT cycles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
        end else begin
            press <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                cnt   <= '0;
                level <= sync2;
                press <= sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run/pause/lap/clear sequencer for the stopwatch counter chain.
// Optional lap view enabled by defining STOPWATCH_LAP_EN.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ      = 12000000,
    parameter int DEBOUNCE_MS = 20,
    parameter int DB_W        = 18
) (
    input logic       clk,
    input logic       rst,
    stopwatch_if.slave bus
);

    localparam int DB_CNT = db_cnt(CLK_HZ, DEBOUNCE_MS);

    logic   ss_p;
    logic   lc_p;
    state_t st;
    logic   cnt_en;
    logic   cnt_clr;
    logic   disp_hold;

    button_debounce #(.DB_CNT(DB_CNT), .DB_W(DB_W)) u_ss (
        .clk   (clk),
        .rst   (rst),
        .raw   (bus.btn_ss),
        .press (ss_p)
    );

    button_debounce #(.DB_CNT(DB_CNT), .DB_W(DB_W)) u_lc (
        .clk   (clk),
        .rst   (rst),
        .raw   (bus.btn_lc),
        .press (lc_p)
    );

    // Control FSM; start/stop outranks lap/clear, ticks gated by old state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st        <= ST_IDLE;
            cnt_en    <= 1'b0;
            cnt_clr   <= 1'b0;
            disp_hold <= 1'b0;
        end else begin
            cnt_en  <= bus.tick_in & ((st == ST_RUN) | (st == ST_LAP));
            cnt_clr <= 1'b0;
            if (ss_p) begin
                unique case (st)
                    ST_IDLE:  st <= ST_RUN;
                    ST_RUN:   st <= ST_PAUSE;
                    ST_PAUSE: st <= ST_RUN;
                    ST_LAP: begin
                        st        <= ST_PAUSE;
                        disp_hold <= 1'b0;
                    end
                endcase
            end else if (lc_p) begin
                unique case (st)
                    ST_IDLE:  cnt_clr <= 1'b1;
                    ST_RUN: begin
`ifdef STOPWATCH_LAP_EN
                        st        <= ST_LAP;
                        disp_hold <= 1'b1;
`else
                        st        <= ST_RUN;
`endif
                    end
                    ST_PAUSE: begin
                        st      <= ST_IDLE;
                        cnt_clr <= 1'b1;
                    end
                    ST_LAP: begin
                        st        <= ST_RUN;
                        disp_hold <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.state     = st;
    assign bus.cnt_en    = cnt_en;
    assign bus.cnt_clr   = cnt_clr;
    assign bus.disp_hold = disp_hold;

endmodule
